// File: rtl/register_file.sv
// register_file: R0-R14 plus NZCV flags with write-through read bypass and condition-pass evaluation.
module register_file #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            ra1,
   input  logic [3:0]            ra2,
   input  logic [3:0]            ra3,
   output logic [DATA_WIDTH-1:0] rd1,
   output logic [DATA_WIDTH-1:0] rd2,
   output logic [DATA_WIDTH-1:0] rd3,
   input  logic [DATA_WIDTH-1:0] pc_plus_8,
   input  logic                  wb_en,
   input  logic [3:0]            wa,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic                  link_en,
   input  logic [DATA_WIDTH-1:0] link_data,
   input  logic                  flags_en,
   input  logic [3:0]            flags_in,
   input  logic [3:0]            cond,
   output logic [3:0]            flags,
   output logic                  cond_pass
);
   logic [DATA_WIDTH-1:0] regs [15];
   logic [3:0]            f;
   logic [7:0]            base;

   function automatic logic [DATA_WIDTH-1:0] rd_sel(input logic [3:0] ra);
      return (ra == 4'd15)               ? pc_plus_8 :
             reset                       ? '0 :
             (link_en && ra == 4'd14)    ? link_data :
             (wb_en && wa == ra)         ? wd :
                                           regs[ra];
   endfunction

   assign rd1 = rd_sel(ra1);
   assign rd2 = rd_sel(ra2);
   assign rd3 = rd_sel(ra3);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 15; i++) regs[i] <= '0;
         flags <= '0;
      end else begin
         if (wb_en && wa != 4'd15) regs[wa] <= wd;
         if (link_en) regs[14] <= link_data;
         if (flags_en) flags <= flags_in;
      end
   end

   // Odd condition codes are the inverse of the even one below them; 1111 inverts AL to never.
   always_comb begin
      f = reset ? 4'b0000 : flags_en ? flags_in : flags;
      base = {1'b1, ~f[2] & (f[3] == f[0]), f[3] == f[0], f[1] & ~f[2], f[0], f[3], f[1], f[2]};
      cond_pass = base[cond[3:1]] ^ cond[0];
   end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of reads, bypass, R15, link collision, flags and reset.
module tb_register_file;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  ra1, ra2, ra3, wa, flags_in, cond, flags;
   logic [31:0] rd1, rd2, rd3, pc_plus_8, wd, link_data;
   logic        wb_en, link_en, flags_en, cond_pass;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   register_file #(.DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .ra3(ra3),
      .rd1(rd1), .rd2(rd2), .rd3(rd3), .pc_plus_8(pc_plus_8),
      .wb_en(wb_en), .wa(wa), .wd(wd), .link_en(link_en), .link_data(link_data),
      .flags_en(flags_en), .flags_in(flags_in), .cond(cond), .flags(flags), .cond_pass(cond_pass)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; ra1 = 0; ra2 = 0; ra3 = 0; wa = 0; wd = 0; pc_plus_8 = 0;
      wb_en = 0; link_en = 0; link_data = 0; flags_en = 0; flags_in = 0; cond = 0;
      tick(); tick();
      reset = 1'b0;
      // reset clear
      wb_en = 1; wa = 3; wd = 32'hDEADBEEF;
      tick();
      wb_en = 0; ra1 = 3; #1;
      check("r3_stored", rd1, 32'hDEADBEEF);
      reset = 1'b1; #1;
      check("rd1_in_reset_comb", rd1, 32'h0);
      tick(); tick();
      ra2 = 15; pc_plus_8 = 32'h0000_0040; cond = 4'b0000; #1;
      check("rd1_reset", rd1, 32'h0);
      check("rd2_r15_reset", rd2, 32'h40);
      check("flags_reset", {28'h0, flags}, 32'h0);
      check("eq_reset", {31'h0, cond_pass}, 32'h0);
      cond = 4'b0001; #1;
      check("ne_reset", {31'h0, cond_pass}, 32'h1);
      cond = 4'b1110; #1;
      check("al_reset", {31'h0, cond_pass}, 32'h1);
      reset = 1'b0; #1;
      check("r3_after_reset", rd1, 32'h0);
      // write-through bypass
      wb_en = 1; wa = 5; wd = 32'h12345678; ra1 = 5; ra2 = 5; ra3 = 5; #1;
      check("byp_rd1", rd1, 32'h12345678);
      check("byp_rd2", rd2, 32'h12345678);
      check("byp_rd3", rd3, 32'h12345678);
      tick();
      wb_en = 0; #1;
      check("r5_stored", rd1, 32'h12345678);
      // R15 handling
      pc_plus_8 = 32'h10; ra2 = 15; #1;
      check("r15_pc", rd2, 32'h10);
      wb_en = 1; wa = 15; wd = 32'hFFFFFFFF; #1;
      check("r15_wb_ignored", rd2, 32'h10);
      tick();
      wb_en = 0; pc_plus_8 = 32'h14; #1;
      check("r15_pc_change", rd2, 32'h14);
      check("r5_untouched", rd1, 32'h12345678);
      // link collision
      wb_en = 1; wa = 14; wd = 32'h0000AAAA; link_en = 1; link_data = 32'h18; ra3 = 14; #1;
      check("link_bypass", rd3, 32'h18);
      tick();
      wb_en = 0; link_en = 0; #1;
      check("link_stored", rd3, 32'h18);
      // flags and conditions
      flags_en = 1; flags_in = 4'b0100; cond = 4'b0000; #1;
      check("eq_bypass", {31'h0, cond_pass}, 32'h1);
      check("flags_old", {28'h0, flags}, 32'h0);
      tick();
      flags_en = 0; #1;
      check("flags_new", {28'h0, flags}, 32'h4);
      check("eq_stored", {31'h0, cond_pass}, 32'h1);
      cond = 4'b0001; #1;
      check("ne_stored", {31'h0, cond_pass}, 32'h0);
      flags_en = 1; flags_in = 4'b1000; cond = 4'b1101; #1;
      check("le_nv", {31'h0, cond_pass}, 32'h1);
      cond = 4'b1111; #1;
      check("never", {31'h0, cond_pass}, 32'h0);
      tick();
      flags_en = 0; cond = 4'b1010; #1;
      check("flags_1000", {28'h0, flags}, 32'h8);
      check("ge_nv", {31'h0, cond_pass}, 32'h0);
      cond = 4'b1011; #1;
      check("lt_nv", {31'h0, cond_pass}, 32'h1);
      cond = 4'b0100; #1;
      check("mi", {31'h0, cond_pass}, 32'h1);
      cond = 4'b1000; #1;
      check("hi_c0", {31'h0, cond_pass}, 32'h0);
      cond = 4'b1001; #1;
      check("ls_c0", {31'h0, cond_pass}, 32'h1);
      flags_en = 1; flags_in = 4'b0010; cond = 4'b1000; #1;
      check("hi_c1", {31'h0, cond_pass}, 32'h1);
      cond = 4'b0010; #1;
      check("cs", {31'h0, cond_pass}, 32'h1);
      flags_in = 4'b1001; cond = 4'b1100; #1;
      check("gt_nv_eq", {31'h0, cond_pass}, 32'h1);
      cond = 4'b0110; #1;
      check("vs", {31'h0, cond_pass}, 32'h1);
      flags_en = 0;
      // reset mid-operation
      reset = 1; wb_en = 1; wa = 2; wd = 32'h55; flags_en = 1; flags_in = 4'b1111; ra1 = 2;
      tick();
      reset = 0; wb_en = 0; flags_en = 0; #1;
      check("r2_reset_lost", rd1, 32'h0);
      check("flags_reset_lost", {28'h0, flags}, 32'h0);
      // writes right after reset, back-to-back to one register, simultaneous wb + link
      wb_en = 1; wa = 8; wd = 32'h1; ra1 = 8;
      tick();
      wd = 32'h2; link_en = 1; link_data = 32'hCAFE0000;
      tick();
      wb_en = 0; link_en = 0; ra3 = 14; ra2 = 5; #1;
      check("b2b_last_wins", rd1, 32'h2);
      check("link_same_edge", rd3, 32'hCAFE0000);
      check("r5_cleared", rd2, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/register_file.md
# register_file

Architectural register file and status-flag unit for the ID stage of the ARM pipeline. It holds R0–R14 and the NZCV flags. It supplies the RD1/RD2/RD3 operands that the ID/EX register latches, and it accepts write-back results from the MEM/WB stage. It also accepts link writes for BL and flag updates from EX for S-bit instructions, and produces the condition-pass decision used to squash instructions whose condition fails.

## Interface
- DATA_WIDTH, 32, register and data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ra1  in  4  read address 1 (Rn, IF_ID_Instr[19:16]).
- ra2  in  4  read address 2 (Rm, IF_ID_Instr[3:0]).
- ra3  in  4  read address 3 (Rd for stores / Rs for register shifts).
- rd1  out  DATA_WIDTH  read data 1.
- rd2  out  DATA_WIDTH  read data 2.
- rd3  out  DATA_WIDTH  read data 3.
- pc_plus_8  in  DATA_WIDTH  value returned for any read of R15.
- wb_en  in  1  write-back enable (MEM_WB_RegWrite).
- wa  in  4  write-back address (MEM_WB_WA).
- wd  in  DATA_WIDTH  write-back data (the MemtoReg-selected result).
- link_en  in  1  BL link write enable; targets R14.
- link_data  in  DATA_WIDTH  return address for BL.
- flags_en  in  1  flag update enable (S-bit instruction in EX).
- flags_in  in  4  new flags {N,Z,C,V}.
- cond  in  4  condition field of the instruction in ID (IF_ID_Instr[31:28]).
- flags  out  4  current registered {N,Z,C,V}.
- cond_pass  out  1  1 when `cond` is satisfied.

## Operation
- Storage is 15 registers (R0–R14) of DATA_WIDTH bits plus a 4-bit flags register. R15 has no storage.
- **Reads** are combinational on all three ports, with identical per-port rules applied in priority order:
  1. If ra==15, return pc_plus_8.
  2. If reset==1, return 0.
  3. If link_en and ra==14, return link_data.
  4. If wb_en and wa==ra, return wd.
  5. Otherwise return the stored register.
- **Writes** occur on the rising edge of clk:
  - reset: all registers and flags are cleared to 0. Reset has priority over every write.
  - wb_en with wa!=15: R[wa] <= wd. A write with wa==15 is silently dropped; the PC is owned by program_counter.
  - link_en: R14 <= link_data.
  - wb_en with wa==14 and link_en in the same cycle: link_data wins (BL is the younger instruction).
  - flags_en: flags <= flags_in.
- **Condition evaluation** uses effective flags F = flags_en ? flags_in : flags. While reset is high, F = 0000.
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 0 (treated as never).
- No arithmetic is performed. All data paths are pass-through at DATA_WIDTH; no truncation or extension.

## Timing
- Read latency is 0 cycles (combinational). A write presented in cycle N is visible on rd* in cycle N via the bypass, and from storage in cycle N+1 onward.
- Flag update latency: cond_pass reflects flags_in in the same cycle that flags_en is high. `flags` shows the new value from the next cycle.
- Reset values: all registers 0, flags 0000. During reset, rd* = 0 for ra!=15 and = pc_plus_8 for ra==15; cond_pass is evaluated on 0000 (EQ→0, NE→1, AL→1).
- Reset asserted on the same edge as wb_en, link_en or flags_en: storage ends at 0 and the writes are lost.
- Reset deasserted: writes take effect from the first edge with reset low.
- Simultaneous writes to different registers complete on the same edge. Back-to-back writes to the same register in consecutive cycles: the last one wins.

## Test plan
- Reset clear: write R3=0xDEADBEEF, then hold reset for 2 cycles → rd1(ra1=3)=0x00000000, flags=0000, cond_pass=0 for cond=0000 and 1 for cond=1110.
- Write-through bypass: wb_en=1, wa=5, wd=0x12345678, ra1=ra2=ra3=5 → all rd*=0x12345678 in the same cycle. Next cycle with wb_en=0 → still 0x12345678.
- R15 handling: pc_plus_8=0x00000010, ra2=15 → rd2=0x10. Then wb_en=1, wa=15, wd=0xFFFFFFFF → rd2 stays 0x10. Change pc_plus_8 to 0x14 → rd2=0x14 immediately.
- Link collision: wb_en=1, wa=14, wd=0x0000AAAA together with link_en=1, link_data=0x00000018 → rd3(ra3=14)=0x18 in the same cycle, and R14=0x18 after the edge.
- Flags and conditions: flags_en=1, flags_in=0100, cond=0000 → cond_pass=1 in the same cycle; flags=0100 next cycle. Then cond=0001 → 0. Then flags_in=1000 with flags_en=1 and cond=1101 (LE, N!=V) → 1. Then cond=1111 → 0.
- Reset mid-operation: reset=1 with wb_en=1, wa=2, wd=0x55 and flags_en=1, flags_in=1111 on the same edge → after reset drops, rd1(ra1=2)=0 and flags=0000.
